// File: rtl/note_tone_generator.sv
// Note tone generator: square-wave note with full-amplitude sustain followed
// by an eight-step exponential decay, streamed as one sample per codec write.
module note_tone_generator #(
  parameter logic [31:0] AMPLITUDE    = 32'h0100_0000,
  parameter int          PLAY_SAMPLES = 9600,
  parameter int          DECAY_STEP   = 600
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        note_valid,
  input  logic [2:0]  note_id,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        busy
);

  // The duration counter serves both PLAY and DECAY, so size it for the larger.
  localparam int DUR_MAX = (PLAY_SAMPLES > DECAY_STEP) ? PLAY_SAMPLES : DECAY_STEP;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam logic [DUR_W-1:0] PLAY_LAST  = DUR_W'(PLAY_SAMPLES - 1);
  localparam logic [DUR_W-1:0] DECAY_LAST = DUR_W'(DECAY_STEP - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DECAY} state_t;

  state_t           state, state_next;
  logic [2:0]       note_q, note_next;
  logic [6:0]       half_cnt, half_next;
  logic [6:0]       half_last;
  logic [DUR_W-1:0] dur_cnt, dur_next;
  logic [2:0]       shift, shift_next;
  logic             phase, phase_next;
  logic signed [31:0] base;
  logic signed [31:0] sample;

  // Handshake: the controller takes one sample in every cycle where
  // write_audio_out is high; that is exactly audio_out_allowed outside reset,
  // so the codec is fed continuously, including silence in IDLE.
  assign write_audio_out = audio_out_allowed & ~reset;

  // Half-period (in samples, minus one) of the latched note at 48 kHz.
  always_comb begin
    half_last = 7'd91;
    case (note_q)
      3'd0: half_last = 7'd91;
      3'd1: half_last = 7'd81;
      3'd2: half_last = 7'd72;
      3'd3: half_last = 7'd68;
      3'd4: half_last = 7'd60;
      3'd5: half_last = 7'd54;
      3'd6: half_last = 7'd48;
      3'd7: half_last = 7'd45;
      default: half_last = 7'd91;
    endcase
  end

  // State register and counters; reset aborts any note immediately.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      note_q   <= 3'd0;
      half_cnt <= 7'd0;
      dur_cnt  <= '0;
      shift    <= 3'd0;
      phase    <= 1'b0;
    end else begin
      state    <= state_next;
      note_q   <= note_next;
      half_cnt <= half_next;
      dur_cnt  <= dur_next;
      shift    <= shift_next;
      phase    <= phase_next;
    end
  end

  // Next-state logic: a note request overrides everything; otherwise the
  // tone and duration counters advance only on cycles that write a sample.
  always_comb begin
    state_next = state;
    note_next  = note_q;
    half_next  = half_cnt;
    dur_next   = dur_cnt;
    shift_next = shift;
    phase_next = phase;
    if (note_valid) begin
      state_next = PLAY;
      note_next  = note_id;
      half_next  = 7'd0;
      dur_next   = '0;
      shift_next = 3'd0;
      phase_next = 1'b0;
    end else if (write_audio_out && (state != IDLE)) begin
      if (half_cnt == half_last) begin
        half_next  = 7'd0;
        phase_next = ~phase;
      end else begin
        half_next = half_cnt + 7'd1;
      end
      case (state)
        PLAY: begin
          if (dur_cnt == PLAY_LAST) begin
            state_next = DECAY;
            dur_next   = '0;
            shift_next = 3'd0;
          end else begin
            dur_next = dur_cnt + DUR_W'(1);
          end
        end
        DECAY: begin
          if (dur_cnt == DECAY_LAST) begin
            dur_next = '0;
            if (shift == 3'd7) begin
              // Note finished: park everything at its idle value.
              state_next = IDLE;
              shift_next = 3'd0;
              half_next  = 7'd0;
              phase_next = 1'b0;
            end else begin
              shift_next = shift + 3'd1;
            end
          end else begin
            dur_next = dur_cnt + DUR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sample value from registered state only; sign follows phase, decay
  // attenuates by arithmetic shift so the waveform stays symmetric.
  always_comb begin
    base   = phase ? $signed(32'd0 - AMPLITUDE) : $signed(AMPLITUDE);
    sample = 32'sd0;
    case (state)
      PLAY:    sample = base;
      DECAY:   sample = base >>> shift;
      default: sample = 32'sd0;
    endcase
  end

  assign left_channel_audio_out  = sample;
  assign right_channel_audio_out = sample;
  assign busy                    = (state != IDLE);

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: a write-count model predicts every output
// each cycle, with hand-computed literal points along the way.
module tb_note_tone_generator;

  localparam logic [31:0] AMP   = 32'h0100_0000;
  localparam logic [31:0] NAMP  = 32'hFF00_0000;
  localparam int          PLAY  = 9600;
  localparam int          DSTEP = 600;
  localparam int          TOTAL = PLAY + 8 * DSTEP;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        note_valid = 1'b0;
  logic [2:0]  note_id = 3'd0;
  logic        allowed = 1'b0;
  logic        write_audio_out;
  logic [31:0] left, right;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  int hp_table [8] = '{92, 82, 73, 69, 61, 55, 49, 46};

  // Model: a note is just a count of writes since it started.
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_hp     = 92;

  always #5 clk = ~clk;

  note_tone_generator dut (
    .CLOCK_50                (clk),
    .reset                   (rst),
    .note_valid              (note_valid),
    .note_id                 (note_id),
    .audio_out_allowed       (allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left),
    .right_channel_audio_out (right),
    .busy                    (busy)
  );

  // Model update on each edge, or at once on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_n      = 0;
      m_hp     = 92;
    end else if (note_valid) begin
      m_active = 1'b1;
      m_n      = 0;
      m_hp     = hp_table[note_id];
    end else if (allowed && m_active) begin
      m_n++;
      if (m_n == TOTAL) m_active = 1'b0;
    end
  end

  function automatic logic [31:0] exp_sample();
    logic signed [31:0] b;
    int sh;
    if (!m_active) return 32'd0;
    b = (((m_n / m_hp) % 2) == 1) ? -$signed(AMP) : $signed(AMP);
    if (m_n < PLAY) return b;
    sh = (m_n - PLAY) / DSTEP;
    return b >>> sh;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard compare on every falling edge.
  always @(negedge clk) begin
    check("write", {31'd0, write_audio_out}, {31'd0, allowed & ~rst});
    check("left",  left,  exp_sample());
    check("right", right, exp_sample());
    check("busy",  {31'd0, busy}, {31'd0, m_active});
  end

  // Driver tasks: inputs change 1 time unit after a falling edge.
  task automatic tick();
    #1 note_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_note(input logic [2:0] id);
    #1 note_valid = 1'b1;
    note_id = id;
    @(negedge clk);
  endtask

  task automatic wait_n(input int target);
    int budget = 40000;
    while (m_n != target && budget > 0) begin
      tick();
      budget--;
    end
    if (m_n != target) check("wait_timeout", m_n, target);
  endtask

  initial begin
    #1 rst = 1'b1;
    allowed = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_write", {31'd0, write_audio_out}, 32'd0);
    check("rst_left",  left, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Idle after reset: continuous zero writes.
    repeat (3) begin
      check("idle_write", {31'd0, write_audio_out}, 32'd1);
      check("idle_left",  left, 32'd0);
      check("idle_busy",  {31'd0, busy}, 32'd0);
      tick();
    end

    // Note 5: half period 55 writes.
    start_note(3'd5);
    check("n5_w1",   left, AMP);
    check("n5_busy", {31'd0, busy}, 32'd1);
    wait_n(54);  check("n5_w55",  left, AMP);
    wait_n(55);  check("n5_w56",  left, NAMP);
    wait_n(109); check("n5_w110", left, NAMP);
    wait_n(110); check("n5_w111", left, AMP);

    // Note 0 full length, including decay and the return to idle.
    start_note(3'd0);
    wait_n(9600);  check("n0_w9601",  left, 32'h0100_0000);
    check("n0_w9601_r", right, 32'h0100_0000);
    wait_n(10200); check("n0_w10201", left, 32'h0080_0000);
    wait_n(14399); check("n0_w14400", left, 32'h0002_0000);
    check("n0_w14400_busy", {31'd0, busy}, 32'd1);
    wait_n(14400); check("n0_w14401", left, 32'd0);
    check("n0_end_busy", {31'd0, busy}, 32'd0);

    // Note 7 with writes allowed every other cycle: 92 clocks per half period.
    start_note(3'd7);
    for (int i = 1; i <= 184; i++) begin
      #1 note_valid = 1'b0;
      allowed = ~allowed;
      @(negedge clk);
      if (i == 91)  check("n7_i91",  left, AMP);
      if (i == 92)  check("n7_i92",  left, NAMP);
      if (i == 183) check("n7_i183", left, NAMP);
      if (i == 184) check("n7_i184", left, AMP);
    end

    // Note request with writes blocked still starts the note.
    #1 allowed = 1'b0;
    start_note(3'd3);
    tick();
    tick();
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_left", left, AMP);
    check("stall_n",    m_n, 32'd0);

    // Retrigger during decay.
    #1 allowed = 1'b1;
    note_valid = 1'b0;
    @(negedge clk);
    start_note(3'd2);
    wait_n(PLAY + 299);
    start_note(3'd4);
    check("rt_first", left, AMP);
    check("rt_busy",  {31'd0, busy}, 32'd1);
    wait_n(60);    check("rt_w61",  left, AMP);
    wait_n(61);    check("rt_w62",  left, NAMP);
    wait_n(14399); check("rt_last_busy", {31'd0, busy}, 32'd1);
    wait_n(14400); check("rt_end_busy",  {31'd0, busy}, 32'd0);

    // Reset mid-note aborts immediately.
    start_note(3'd6);
    wait_n(4999);
    #1 rst = 1'b1;
    note_valid = 1'b0;
    #1;
    check("ar_left",  left, 32'd0);
    check("ar_right", right, 32'd0);
    check("ar_busy",  {31'd0, busy}, 32'd0);
    check("ar_write", {31'd0, write_audio_out}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ar_rel_write", {31'd0, write_audio_out}, 32'd1);
    check("ar_rel_left",  left, 32'd0);
    start_note(3'd1);
    wait_n(81);  check("n1_w82", left, AMP);
    wait_n(82);  check("n1_w83", left, NAMP);
    wait_n(164); check("n1_w165", left, AMP);

    // Random stimulus against the model.
    for (int c = 0; c < 6000; c++) begin
      #1 note_valid = ($urandom_range(0, 199) == 0);
      note_id = 3'($urandom_range(0, 7));
      allowed = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    #1 rst = 1'b0;
    note_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
